// File: rtl/tf_gen_seq_if.sv
// rtl/tf_gen_seq_if.sv - TF_* strobe / twiddle output bundle between NTT controller and tf_gen_seq
interface tf_gen_seq_if #(
    parameter int DW = 16,
    parameter int SW = 8
);
    logic          TF_init_const;
    logic          TF_init_base;
    logic          TF_ren;
    logic          TF_wen;
    logic [DW-1:0] tf_wdata;
    logic [SW-1:0] it_depth_cnt;
    logic [DW-1:0] tf_out;
    logic          tf_valid;
    logic          tf_ready;
    logic          tf_err;

    modport master (
        output TF_init_const, TF_init_base, TF_ren, TF_wen, tf_wdata, it_depth_cnt,
        input  tf_out, tf_valid, tf_ready, tf_err
    );

    modport slave (
        input  TF_init_const, TF_init_base, TF_ren, TF_wen, tf_wdata, it_depth_cnt,
        output tf_out, tf_valid, tf_ready, tf_err
    );
endinterface

// File: rtl/tf_gen_seq.sv
// rtl/tf_gen_seq.sv - twiddle-factor generator: per-stage step-root precompute and twiddle sequencing
module tf_gen_seq #(
    parameter int DW        = 16,
    parameter int P         = 12289,
    parameter int OMEGA     = 49,
    parameter int STAGES    = 3,
    parameter int RADIX_LOG = 4,
    parameter int SW        = 8
) (
    input  logic         clk,
    input  logic         rst,
    tf_gen_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PRECOMP, READY} state_t;

    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int QW = (RADIX_LOG > 1) ? $clog2(RADIX_LOG) : 1;
    localparam logic [2*DW-1:0] P_W = (2*DW)'(P);

    function automatic logic [DW-1:0] modmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        modmul = DW'(prod % P_W);
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] step_q [STAGES];
    logic [DW-1:0] step_d [STAGES];
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] work_q, work_d;
    logic [QW-1:0] sq_cnt_q, sq_cnt_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [SW-1:0] last_q, last_d;
    logic [DW-1:0] tf_out_q, tf_out_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          const_prev_q;

    logic          in_range;
    logic [IW-1:0] sel;
    logic [DW-1:0] sq_val;
    logic [DW-1:0] next_acc;

    assign in_range = (bus.it_depth_cnt < SW'(STAGES));
    assign sel      = bus.it_depth_cnt[IW-1:0];
    assign sq_val   = modmul(work_q, work_q);
    assign next_acc = modmul(acc_q, step_q[sel]);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        acc_d    = acc_q;
        work_d   = work_q;
        sq_cnt_d = sq_cnt_q;
        wr_idx_d = wr_idx_q;
        last_d   = last_q;
        tf_out_d = tf_out_q;
        valid_d  = 1'b0;
        err_d    = err_q;

        if (bus.TF_ren && state_q != READY) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.TF_init_const) begin
                    state_d  = PRECOMP;
                    wr_idx_d = '0;
                    sq_cnt_d = '0;
                end
            end
            PRECOMP: begin
                acc_d = DW'(1);
                // wr_idx_q == 0 marks the seeding cycle; afterwards one squaring per cycle
                if (wr_idx_q == '0) begin
                    step_d[0] = DW'(OMEGA);
                    work_d    = DW'(OMEGA);
                    sq_cnt_d  = '0;
                    if (STAGES == 1) state_d = READY;
                    else             wr_idx_d = IW'(1);
                end else begin
                    work_d = sq_val;
                    if (sq_cnt_q == QW'(RADIX_LOG - 1)) begin
                        step_d[wr_idx_q] = sq_val;
                        sq_cnt_d         = '0;
                        if (wr_idx_q == IW'(STAGES - 1)) state_d = READY;
                        else                             wr_idx_d = wr_idx_q + IW'(1);
                    end else begin
                        sq_cnt_d = sq_cnt_q + QW'(1);
                    end
                end
            end
            READY: begin
                if (bus.TF_init_const && !const_prev_q) begin
                    state_d  = PRECOMP;
                    wr_idx_d = '0;
                    sq_cnt_d = '0;
                end
                if (bus.TF_init_base) begin
                    acc_d = DW'(1);
                end else if (bus.TF_wen) begin
                    acc_d = bus.tf_wdata;
                end else if (bus.TF_ren) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (bus.it_depth_cnt != last_q) begin
                        tf_out_d = DW'(1);
                        acc_d    = step_q[sel];
                        last_d   = bus.it_depth_cnt;
                        valid_d  = 1'b1;
                    end else begin
                        tf_out_d = acc_q;
                        acc_d    = next_acc;
                        valid_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < STAGES; i++) step_q[i] <= '0;
            acc_q        <= DW'(1);
            work_q       <= '0;
            sq_cnt_q     <= '0;
            wr_idx_q     <= '0;
            last_q       <= '0;
            tf_out_q     <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            const_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            work_q       <= work_d;
            sq_cnt_q     <= sq_cnt_d;
            wr_idx_q     <= wr_idx_d;
            last_q       <= last_d;
            tf_out_q     <= tf_out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            const_prev_q <= bus.TF_init_const;
        end
    end

    assign bus.tf_out   = tf_out_q;
    assign bus.tf_valid = valid_q;
    assign bus.tf_ready = (state_q == READY);
    assign bus.tf_err   = err_q;
endmodule

// File: tb/tb_tf_gen_seq.sv
// tb/tb_tf_gen_seq.sv - self-checking bench for tf_gen_seq with a small prime (P=17)
module tb_tf_gen_seq;
    localparam int DW = 16, SW = 8, P = 17, OMEGA = 3, STAGES = 3, RL = 1;
    localparam int TOTAL = 1 + (STAGES - 1) * RL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tf_gen_seq_if #(.DW(DW), .SW(SW)) bus();

    tf_gen_seq #(.DW(DW), .P(P), .OMEGA(OMEGA), .STAGES(STAGES), .RADIX_LOG(RL), .SW(SW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic b, w, r;
        int   wd, d;
        logic ev;
        int   eo;
    } vec_t;
    vec_t vt[$];

    int mstep [STAGES];
    int mbase, mk, mlast, cur_d;
    logic merr;
    int mout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pw(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e % (P - 1); i++) r = (r * b) % P;
        return r;
    endfunction

    task automatic drive(input logic b, input logic w, input logic r, input int wd, input int d);
        bus.TF_init_base = b;
        bus.TF_wen       = w;
        bus.TF_ren       = r;
        bus.tf_wdata     = DW'(wd);
        bus.it_depth_cnt = SW'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic b, input logic w, input logic r, input int wd, input int d,
                        input logic ev, input int eo);
        vec_t v;
        v.b = b; v.w = w; v.r = r; v.wd = wd; v.d = d; v.ev = ev; v.eo = eo;
        vt.push_back(v);
    endtask

    initial begin
        int cnt;
        bus.TF_init_const = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int s = 0; s < STAGES; s++) mstep[s] = pw(OMEGA, 1 << (RL * s));

        // reset values and a read before init
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.tf_out, 0);
        check("rst_valid", bus.tf_valid, 0);
        check("rst_ready", bus.tf_ready, 0);
        check("rst_err", bus.tf_err, 0);
        rst = 1'b1;
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("early_err", bus.tf_err, 1);
        check("early_valid", bus.tf_valid, 0);
        rst = 1'b0;
        #2;
        check("async_rst_err", bus.tf_err, 0);
        rst = 1'b1;
        tick();

        // precompute latency and table contents
        bus.TF_init_const = 1'b1;
        cnt = 0;
        while (cnt < 20 && bus.tf_ready !== 1'b1) begin
            tick();
            cnt++;
        end
        check("ready_latency", cnt, 1 + TOTAL);
        for (int s = 0; s < STAGES; s++) check("step_table", dut.step_q[s], mstep[s]);

        // directed sequence; TF_init_const stays high and must not retrigger
        addv(1, 0, 0, 0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 1, 1);  addv(0, 0, 1, 0, 0, 1, 3);
        addv(0, 0, 1, 0, 0, 1, 9);  addv(0, 0, 1, 0, 0, 1, 10);
        addv(0, 0, 1, 0, 1, 1, 1);  addv(0, 0, 1, 0, 1, 1, 9);
        addv(0, 0, 1, 0, 1, 1, 13); addv(0, 0, 1, 0, 1, 1, 15);
        addv(0, 0, 1, 0, 2, 1, 1);  addv(0, 0, 1, 0, 2, 1, 13);
        addv(0, 0, 1, 0, 2, 1, 16);
        addv(0, 0, 1, 0, 1, 1, 1);
        addv(0, 1, 1, 5, 1, 0, 1);
        addv(0, 0, 1, 0, 1, 1, 5);  addv(0, 0, 1, 0, 1, 1, 11);
        addv(1, 0, 1, 0, 1, 0, 11);
        addv(0, 0, 1, 0, 1, 1, 1);
        foreach (vt[i]) begin
            drive(vt[i].b, vt[i].w, vt[i].r, vt[i].wd, vt[i].d);
            tick();
            check($sformatf("vec%0d_valid", i), bus.tf_valid, vt[i].ev);
            check($sformatf("vec%0d_out", i), bus.tf_out, vt[i].eo);
            check($sformatf("vec%0d_ready", i), bus.tf_ready, 1);
            check($sformatf("vec%0d_err", i), bus.tf_err, 0);
        end

        // random traffic against an exponent-tracking model: out = base * step^k
        mbase = 1; mk = 1; mlast = 1; cur_d = 1; merr = 1'b0; mout = 1;
        for (int it = 0; it < 400; it++) begin
            logic b, w, r, ev;
            int wd;
            b  = ($urandom_range(0, 9) == 0);
            w  = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 3) != 0);
            wd = $urandom_range(0, P - 1);
            if ($urandom_range(0, 7) == 0) cur_d = $urandom_range(0, 3);
            ev = 1'b0;
            if (b) begin
                mbase = 1; mk = 0;
            end else if (w) begin
                mbase = wd; mk = 0;
            end else if (r) begin
                if (cur_d >= STAGES) merr = 1'b1;
                else begin
                    if (cur_d != mlast) begin
                        mbase = 1; mk = 0; mlast = cur_d;
                    end
                    mout = (mbase * pw(mstep[cur_d], mk)) % P;
                    mk = (mk + 1) % (P - 1);
                    ev = 1'b1;
                end
            end
            drive(b, w, r, wd, cur_d);
            tick();
            check("rnd_valid", bus.tf_valid, ev);
            check("rnd_out", bus.tf_out, mout);
            check("rnd_err", bus.tf_err, merr);
        end

        // out-of-range stage leaves the accumulator alone
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0); tick();
        check("rng_first", bus.tf_out, 1);
        drive(0, 0, 1, 0, 0); tick();
        check("rng_second", bus.tf_out, 3);
        drive(0, 0, 1, 0, 3); tick();
        check("rng_err", bus.tf_err, 1);
        check("rng_valid", bus.tf_valid, 0);
        check("rng_hold", bus.tf_out, 3);
        drive(0, 0, 1, 0, 0); tick();
        check("rng_resume", bus.tf_out, 9);
        check("rng_resume_valid", bus.tf_valid, 1);
        drive(0, 0, 0, 0, 0);

        // rising TF_init_const retriggers; reset mid-precompute clears everything
        bus.TF_init_const = 1'b0; tick();
        bus.TF_init_const = 1'b1; tick();
        tick();
        check("retrig_ready", bus.tf_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready", bus.tf_ready, 0);
        check("midrst_out", bus.tf_out, 0);
        check("midrst_err", bus.tf_err, 0);
        for (int s = 0; s < STAGES; s++) check("midrst_table", dut.step_q[s], 0);
        bus.TF_init_const = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_ready", bus.tf_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
